// File: rtl/xadac_pkg.sv
// Shared definitions for the XADAC dispatcher slice.
//
// Contents:
//   - bus widths used by the xadac_if interface
//   - SbLen:         default number of outstanding requests
//   - order_entry_t: order-FIFO entry (destination unit index plus LOCAL bit)
//   - DefaultMask / DefaultMatch: default decode constant arrays (all zero)
//   - decode_hit():  single-unit instruction decode test
package xadac_pkg;

    localparam int InstrWidth = 32;
    localparam int DataWidth  = 32;
    localparam int MaxMst     = 16;
    localparam int UnitWidth  = 4;
    localparam int SbLen      = 4;

    // One entry per accepted request, recording where its response comes from.
    // is_local marks a request answered by the dispatcher itself.
    typedef struct packed {
        logic                 is_local;
        logic [UnitWidth-1:0] unit;
    } order_entry_t;

    localparam logic [MaxMst-1:0][InstrWidth-1:0] DefaultMask  = '0;
    localparam logic [MaxMst-1:0][InstrWidth-1:0] DefaultMatch = '0;

    function automatic logic decode_hit(input logic [InstrWidth-1:0] instr,
                                        input logic [InstrWidth-1:0] mask,
                                        input logic [InstrWidth-1:0] match);
        return (instr & mask) == match;
    endfunction

endpackage

// File: rtl/xadac_if.sv
// XADAC request/response channel bundle.
//
// Signals:
//   req_valid / req_ready   request handshake
//   req_instr, req_payload  request contents
//   rsp_valid / rsp_ready   response handshake
//   rsp_payload, rsp_err    response contents
//
// Modports:
//   mst  drives requests and accepts responses (initiator side)
//   slv  accepts requests and drives responses (target side)
interface xadac_if;
    import xadac_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [InstrWidth-1:0] req_instr;
    logic [DataWidth-1:0]  req_payload;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DataWidth-1:0]  rsp_payload;
    logic                  rsp_err;

    modport mst (
        output req_valid, req_instr, req_payload, rsp_ready,
        input  req_ready, rsp_valid, rsp_payload, rsp_err
    );

    modport slv (
        input  req_valid, req_instr, req_payload, rsp_ready,
        output req_ready, rsp_valid, rsp_payload, rsp_err
    );

endinterface

// File: rtl/xadac_dispatch_fifo.sv
// Synchronous order FIFO for the XADAC dispatcher.
//
// Parameters:
//   Depth    number of entries (power of two, >= 2)
//   entry_t  stored entry type
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wr_data   write request; ignored while full (no bypass through a pop)
//   pop             read request; ignored while empty
//   rd_data         entry at the head (valid while !empty)
//   full, empty     occupancy flags
//   count           number of stored entries, 0..Depth
module xadac_dispatch_fifo #(
    parameter int  Depth   = 4,
    parameter type entry_t = logic
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     wr_data,
    input  logic                       pop,
    output entry_t                     rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth+1)-1:0] count
);

    localparam int PtrWidth = $clog2(Depth);
    localparam int CntWidth = $clog2(Depth+1);

    entry_t              mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == CntWidth'(Depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/xadac_dispatch.sv
// XADAC dispatcher: routes upstream requests to one of NoMst units by
// instruction decode and returns the unit responses in acceptance order.
//
// Parameters:
//   NoMst   number of unit ports (2..16)
//   Depth   maximum outstanding requests (power of two, 2..32)
//   Mask    per-unit instruction decode masks
//   Match   per-unit instruction decode match values
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   slv          upstream port (requests in, responses out)
//   mst[NoMst]   per-unit downstream ports
//   outstanding  accepted requests not yet responded
//
// Build option:
//   XADAC_DISPATCH_ERR_RSP_EN  unmatched instructions are answered locally
//                              with err=1 instead of going to unit NoMst-1.
module xadac_dispatch
    import xadac_pkg::*;
#(
    parameter int                                 NoMst = 4,
    parameter int                                 Depth = SbLen,
    parameter logic [NoMst-1:0][InstrWidth-1:0]   Mask  = DefaultMask[NoMst-1:0],
    parameter logic [NoMst-1:0][InstrWidth-1:0]   Match = DefaultMatch[NoMst-1:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    xadac_if.slv                       slv,
    xadac_if.mst                       mst [NoMst],
    output logic [$clog2(Depth+1)-1:0] outstanding
);

    logic [NoMst-1:0]     unit_req_ready;
    logic [NoMst-1:0]     unit_rsp_valid;
    logic [DataWidth-1:0] unit_rsp_payload [NoMst];

    logic [UnitWidth-1:0] sel;
    logic                 is_local;
    logic                 dest_ready;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    order_entry_t         push_entry;
    order_entry_t         head;
    logic                 head_unit_valid;
    logic [DataWidth-1:0] head_unit_payload;
    logic                 rsp_valid;
    logic [DataWidth-1:0] rsp_payload;
    logic                 rsp_err;
`ifdef XADAC_DISPATCH_ERR_RSP_EN
    logic                 hit;
`endif

    // Per-unit wiring. Only the decoded unit sees req_valid, and only the
    // unit at the FIFO head sees rsp_ready; everything else is held back.
    for (genvar i = 0; i < NoMst; i++) begin : g_unit
        assign unit_req_ready[i]   = mst[i].req_ready;
        assign unit_rsp_valid[i]   = mst[i].rsp_valid;
        assign unit_rsp_payload[i] = mst[i].rsp_payload;
        assign mst[i].req_valid    = !rst && slv.req_valid && !full && !is_local
                                     && (sel == UnitWidth'(i));
        assign mst[i].req_instr    = slv.req_instr;
        assign mst[i].req_payload  = slv.req_payload;
        assign mst[i].rsp_ready    = !rst && !empty && !head.is_local
                                     && (head.unit == UnitWidth'(i)) && slv.rsp_ready;
    end

    // Decode: scanning downwards lets the lowest matching index win. With no
    // match, sel stays at the last unit, which is the fallback destination.
    always_comb begin
        sel = UnitWidth'(NoMst-1);
`ifdef XADAC_DISPATCH_ERR_RSP_EN
        hit = 1'b0;
`endif
        for (int i = NoMst-1; i >= 0; i--) begin
            if (decode_hit(slv.req_instr, Mask[i], Match[i])) begin
                sel = UnitWidth'(i);
`ifdef XADAC_DISPATCH_ERR_RSP_EN
                hit = 1'b1;
`endif
            end
        end
    end

`ifdef XADAC_DISPATCH_ERR_RSP_EN
    assign is_local = !hit;
`else
    assign is_local = 1'b0;
`endif

    // A locally answered request needs no unit, so it is always ready.
    always_comb begin
        dest_ready = is_local;
        for (int i = 0; i < NoMst; i++) begin
            if (!is_local && (sel == UnitWidth'(i))) dest_ready = unit_req_ready[i];
        end
    end

    assign slv.req_ready    = !rst && !full && dest_ready;
    assign push             = slv.req_valid && slv.req_ready;
    assign push_entry.is_local = is_local;
    assign push_entry.unit     = is_local ? '0 : sel;

    xadac_dispatch_fifo #(
        .Depth   (Depth),
        .entry_t (order_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (outstanding)
    );

    // Pick out the response channel of the unit owning the oldest request.
    always_comb begin
        head_unit_valid   = 1'b0;
        head_unit_payload = '0;
        for (int i = 0; i < NoMst; i++) begin
            if (head.unit == UnitWidth'(i)) begin
                head_unit_valid   = unit_rsp_valid[i];
                head_unit_payload = unit_rsp_payload[i];
            end
        end
    end

    // Upstream response: nothing while empty, a held error response for a
    // LOCAL head, otherwise the head unit's response with err cleared.
    always_comb begin
        rsp_valid   = 1'b0;
        rsp_payload = '0;
        rsp_err     = 1'b0;
        if (!rst && !empty) begin
            if (head.is_local) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end else begin
                rsp_valid   = head_unit_valid;
                rsp_payload = head_unit_payload;
            end
        end
    end

    assign slv.rsp_valid   = rsp_valid;
    assign slv.rsp_payload = rsp_payload;
    assign slv.rsp_err     = rsp_err;
    assign pop             = rsp_valid && slv.rsp_ready;

endmodule

// File: tb/tb_xadac_dispatch.sv
// Directed testbench for xadac_dispatch (NoMst=4, Depth=4, Mask=0x7F,
// Match={0x0B,0x2B,0x5B,0x7B}). Unmatched-instruction expectations follow
// XADAC_DISPATCH_ERR_RSP_EN.
module tb_xadac_dispatch;
    import xadac_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xadac_if slv_if ();
    xadac_if mst_if [4] ();

    logic [3:0]  unit_req_ready;
    logic [3:0]  unit_rsp_valid;
    logic [3:0]  unit_req_valid;
    logic [3:0]  unit_rsp_ready;
    logic [31:0] unit_rsp_payload [4];
    logic [31:0] unit1_instr;
    logic [2:0]  outstanding;

    int tests  = 0;
    int failed = 0;

    for (genvar g = 0; g < 4; g++) begin : g_unit
        assign mst_if[g].req_ready   = unit_req_ready[g];
        assign mst_if[g].rsp_valid   = unit_rsp_valid[g];
        assign mst_if[g].rsp_payload = unit_rsp_payload[g];
        assign mst_if[g].rsp_err     = 1'b0;
        assign unit_req_valid[g]     = mst_if[g].req_valid;
        assign unit_rsp_ready[g]     = mst_if[g].rsp_ready;
    end
    assign unit1_instr = mst_if[1].req_instr;

    xadac_dispatch #(
        .NoMst (4),
        .Depth (4),
        .Mask  ({4{32'h0000_007F}}),
        .Match ({32'h0000_007B, 32'h0000_005B, 32'h0000_002B, 32'h0000_000B})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .slv         (slv_if),
        .mst         (mst_if),
        .outstanding (outstanding)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle;
        slv_if.req_valid   = 1'b0;
        slv_if.rsp_ready   = 1'b0;
        unit_rsp_valid     = 4'b0000;
        unit_req_ready     = 4'b1111;
    endtask

    task automatic issue(input logic [31:0] instr);
        slv_if.req_valid   = 1'b1;
        slv_if.req_instr   = instr;
        slv_if.req_payload = instr ^ 32'hA5A5_0000;
    endtask

    task automatic test_reset;
        idle();
        issue(32'h0000_002B);
        slv_if.rsp_ready = 1'b1;
        unit_rsp_valid   = 4'b1111;
        rst = 1'b1;
        tick();
        tick();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
        tests++; if (slv_if.req_ready !== 1'b0) begin failed++; $display("[TB] FAIL reset_req_ready: got %b expected 0", slv_if.req_ready); end
        tests++; if (slv_if.rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", slv_if.rsp_valid); end
        tests++; if (unit_req_valid !== 4'b0000) begin failed++; $display("[TB] FAIL reset_mst_req_valid: got %b expected 0000", unit_req_valid); end
        tests++; if (unit_rsp_ready !== 4'b0000) begin failed++; $display("[TB] FAIL reset_mst_rsp_ready: got %b expected 0000", unit_rsp_ready); end
        idle();
        rst = 1'b0;
        tick();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL post_reset_outstanding: got %0d expected 0", outstanding); end
    endtask

    task automatic test_routing;
        idle();
        unit_req_ready = 4'b0010;
        issue(32'h0000_002B);
        settle();
        tests++; if (unit_req_valid !== 4'b0010) begin failed++; $display("[TB] FAIL route_req_valid: got %b expected 0010", unit_req_valid); end
        tests++; if (slv_if.req_ready !== 1'b1) begin failed++; $display("[TB] FAIL route_req_ready: got %b expected 1", slv_if.req_ready); end
        tests++; if (unit1_instr !== 32'h0000_002B) begin failed++; $display("[TB] FAIL route_instr_pass: got %h expected 0000002b", unit1_instr); end
        tick();
        slv_if.req_valid = 1'b0;
        settle();
        tests++; if (outstanding !== 3'd1) begin failed++; $display("[TB] FAIL route_outstanding: got %0d expected 1", outstanding); end
        unit_rsp_valid      = 4'b0010;
        unit_rsp_payload[1] = 32'h0000_00A1;
        slv_if.rsp_ready    = 1'b1;
        settle();
        tests++; if (slv_if.rsp_valid !== 1'b1) begin failed++; $display("[TB] FAIL route_rsp_valid: got %b expected 1", slv_if.rsp_valid); end
        tests++; if (slv_if.rsp_payload !== 32'h0000_00A1) begin failed++; $display("[TB] FAIL route_rsp_payload: got %h expected 000000a1", slv_if.rsp_payload); end
        tests++; if (slv_if.rsp_err !== 1'b0) begin failed++; $display("[TB] FAIL route_rsp_err: got %b expected 0", slv_if.rsp_err); end
        tests++; if (unit_rsp_ready !== 4'b0010) begin failed++; $display("[TB] FAIL route_rsp_ready: got %b expected 0010", unit_rsp_ready); end
        tick();
        idle();
        settle();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL route_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_reorder;
        idle();
        issue(32'h0000_005B);
        tick();
        issue(32'h0000_000B);
        tick();
        slv_if.req_valid = 1'b0;
        settle();
        tests++; if (outstanding !== 3'd2) begin failed++; $display("[TB] FAIL reorder_outstanding: got %0d expected 2", outstanding); end
        unit_rsp_valid      = 4'b0001;
        unit_rsp_payload[0] = 32'h0000_00B0;
        slv_if.rsp_ready    = 1'b1;
        settle();
        tests++; if (slv_if.rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL reorder_hold_valid: got %b expected 0", slv_if.rsp_valid); end
        tests++; if (unit_rsp_ready !== 4'b0100) begin failed++; $display("[TB] FAIL reorder_hold_ready: got %b expected 0100", unit_rsp_ready); end
        tick();
        tests++; if (outstanding !== 3'd2) begin failed++; $display("[TB] FAIL reorder_no_pop: got %0d expected 2", outstanding); end
        unit_rsp_valid      = 4'b0101;
        unit_rsp_payload[2] = 32'h0000_00B2;
        settle();
        tests++; if (slv_if.rsp_valid !== 1'b1) begin failed++; $display("[TB] FAIL reorder_first_valid: got %b expected 1", slv_if.rsp_valid); end
        tests++; if (slv_if.rsp_payload !== 32'h0000_00B2) begin failed++; $display("[TB] FAIL reorder_first_payload: got %h expected 000000b2", slv_if.rsp_payload); end
        tick();
        unit_rsp_valid = 4'b0001;
        settle();
        tests++; if (slv_if.rsp_payload !== 32'h0000_00B0) begin failed++; $display("[TB] FAIL reorder_second_payload: got %h expected 000000b0", slv_if.rsp_payload); end
        tests++; if (unit_rsp_ready !== 4'b0001) begin failed++; $display("[TB] FAIL reorder_second_ready: got %b expected 0001", unit_rsp_ready); end
        tick();
        idle();
        settle();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL reorder_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_full;
        idle();
        issue(32'h0000_007B);
        repeat (4) tick();
        tests++; if (outstanding !== 3'd4) begin failed++; $display("[TB] FAIL full_outstanding: got %0d expected 4", outstanding); end
        tests++; if (slv_if.req_ready !== 1'b0) begin failed++; $display("[TB] FAIL full_req_ready: got %b expected 0", slv_if.req_ready); end
        tests++; if (unit_req_valid !== 4'b0000) begin failed++; $display("[TB] FAIL full_mst_req_valid: got %b expected 0000", unit_req_valid); end
        unit_rsp_valid      = 4'b1000;
        unit_rsp_payload[3] = 32'h0000_00C3;
        slv_if.rsp_ready    = 1'b1;
        settle();
        tests++; if (slv_if.req_ready !== 1'b0) begin failed++; $display("[TB] FAIL full_no_bypass: got %b expected 0", slv_if.req_ready); end
        tests++; if (slv_if.rsp_valid !== 1'b1) begin failed++; $display("[TB] FAIL full_rsp_valid: got %b expected 1", slv_if.rsp_valid); end
        tick();
        unit_rsp_valid   = 4'b0000;
        slv_if.rsp_ready = 1'b0;
        settle();
        tests++; if (outstanding !== 3'd3) begin failed++; $display("[TB] FAIL full_pop_only: got %0d expected 3", outstanding); end
        tests++; if (slv_if.req_ready !== 1'b1) begin failed++; $display("[TB] FAIL full_reopen: got %b expected 1", slv_if.req_ready); end
        tick();
        slv_if.req_valid = 1'b0;
        settle();
        tests++; if (outstanding !== 3'd4) begin failed++; $display("[TB] FAIL full_fifth_accept: got %0d expected 4", outstanding); end
        unit_rsp_valid   = 4'b1000;
        slv_if.rsp_ready = 1'b1;
        repeat (4) tick();
        idle();
        settle();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL full_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_unmatched;
        idle();
`ifdef XADAC_DISPATCH_ERR_RSP_EN
        unit_req_ready = 4'b0000;
        issue(32'h0000_0033);
        settle();
        tests++; if (unit_req_valid !== 4'b0000) begin failed++; $display("[TB] FAIL unmatched_no_mst: got %b expected 0000", unit_req_valid); end
        tests++; if (slv_if.req_ready !== 1'b1) begin failed++; $display("[TB] FAIL unmatched_req_ready: got %b expected 1", slv_if.req_ready); end
        tick();
        slv_if.req_valid = 1'b0;
        tick();
        tests++; if (slv_if.rsp_valid !== 1'b1) begin failed++; $display("[TB] FAIL unmatched_rsp_held: got %b expected 1", slv_if.rsp_valid); end
        tests++; if (slv_if.rsp_err !== 1'b1) begin failed++; $display("[TB] FAIL unmatched_rsp_err: got %b expected 1", slv_if.rsp_err); end
        tests++; if (slv_if.rsp_payload !== 32'h0) begin failed++; $display("[TB] FAIL unmatched_rsp_payload: got %h expected 00000000", slv_if.rsp_payload); end
        tests++; if (unit_rsp_ready !== 4'b0000) begin failed++; $display("[TB] FAIL unmatched_mst_rsp_ready: got %b expected 0000", unit_rsp_ready); end
        slv_if.rsp_ready = 1'b1;
        tick();
`else
        issue(32'h0000_0033);
        settle();
        tests++; if (unit_req_valid !== 4'b1000) begin failed++; $display("[TB] FAIL unmatched_route_last: got %b expected 1000", unit_req_valid); end
        tick();
        slv_if.req_valid = 1'b0;
        settle();
        tests++; if (outstanding !== 3'd1) begin failed++; $display("[TB] FAIL unmatched_outstanding: got %0d expected 1", outstanding); end
        unit_rsp_valid      = 4'b1000;
        unit_rsp_payload[3] = 32'h0000_00E3;
        slv_if.rsp_ready    = 1'b1;
        settle();
        tests++; if (slv_if.rsp_payload !== 32'h0000_00E3) begin failed++; $display("[TB] FAIL unmatched_rsp_payload: got %h expected 000000e3", slv_if.rsp_payload); end
        tests++; if (slv_if.rsp_err !== 1'b0) begin failed++; $display("[TB] FAIL unmatched_rsp_err: got %b expected 0", slv_if.rsp_err); end
        tick();
`endif
        idle();
        settle();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL unmatched_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_reset_midflight;
        idle();
        issue(32'h0000_002B);
        repeat (3) tick();
        slv_if.req_valid = 1'b0;
        settle();
        tests++; if (outstanding !== 3'd3) begin failed++; $display("[TB] FAIL midreset_before: got %0d expected 3", outstanding); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        unit_rsp_valid      = 4'b0010;
        unit_rsp_payload[1] = 32'h0000_00F1;
        slv_if.rsp_ready    = 1'b1;
        settle();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL midreset_outstanding: got %0d expected 0", outstanding); end
        tests++; if (slv_if.rsp_valid !== 1'b0) begin failed++; $display("[TB] FAIL midreset_rsp_valid: got %b expected 0", slv_if.rsp_valid); end
        tests++; if (unit_rsp_ready !== 4'b0000) begin failed++; $display("[TB] FAIL midreset_late_rsp_ready: got %b expected 0000", unit_rsp_ready); end
        tick();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL midreset_stays_empty: got %0d expected 0", outstanding); end
        idle();
    endtask

    task automatic test_back_to_back;
        idle();
        issue(32'h0000_000B);
        tick();
        issue(32'h0000_002B);
        unit_rsp_valid      = 4'b0001;
        unit_rsp_payload[0] = 32'h0000_00D0;
        slv_if.rsp_ready    = 1'b1;
        settle();
        tests++; if (slv_if.req_ready !== 1'b1) begin failed++; $display("[TB] FAIL b2b_req_ready: got %b expected 1", slv_if.req_ready); end
        tests++; if (slv_if.rsp_payload !== 32'h0000_00D0) begin failed++; $display("[TB] FAIL b2b_rsp_payload: got %h expected 000000d0", slv_if.rsp_payload); end
        tick();
        slv_if.req_valid    = 1'b0;
        unit_rsp_valid      = 4'b0010;
        unit_rsp_payload[1] = 32'h0000_00D1;
        settle();
        tests++; if (outstanding !== 3'd1) begin failed++; $display("[TB] FAIL b2b_outstanding: got %0d expected 1", outstanding); end
        tests++; if (slv_if.rsp_payload !== 32'h0000_00D1) begin failed++; $display("[TB] FAIL b2b_next_cycle_rsp: got %h expected 000000d1", slv_if.rsp_payload); end
        tick();
        idle();
        settle();
        tests++; if (outstanding !== 3'd0) begin failed++; $display("[TB] FAIL b2b_drain: got %0d expected 0", outstanding); end
    endtask

    initial begin
        rst                = 1'b1;
        slv_if.req_valid   = 1'b0;
        slv_if.req_instr   = '0;
        slv_if.req_payload = '0;
        slv_if.rsp_ready   = 1'b0;
        unit_req_ready     = 4'b1111;
        unit_rsp_valid     = 4'b0000;
        for (int i = 0; i < 4; i++) unit_rsp_payload[i] = '0;

        test_reset();
        test_routing();
        test_reorder();
        test_full();
        test_unmatched();
        test_reset_midflight();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
